// File: rtl/axi_bridge_pkg.sv
// Shared AXI types and constants for the AXI4-Lite to AXI4 bridge.
// size_for_width() maps a data bus width to the AXI AxSIZE encoding.
package axi_bridge_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  localparam logic [1:0] BURST_INCR      = 2'b01;
  localparam logic [3:0] CACHE_NORMAL_NC = 4'b0011;

  function automatic logic [2:0] size_for_width(input int width);
    logic [2:0] s;
    s = '0;
    for (int i = 0; i < 8; i++)
      if ((8 << i) == width) s = 3'(i);
    return s;
  endfunction

endpackage

// File: rtl/axil2axi_credit_bridge_if.sv
// Lite-side and AXI4-side signal bundle of the credit bridge.
// slave is the bridge view; master is the surrounding environment.
interface axil2axi_credit_bridge_if #(
  parameter int ID_WIDTH   = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  import axi_bridge_pkg::*;

  localparam int SW = DATA_WIDTH / 8;

  logic                  s_awvalid, s_awready;
  logic [ADDR_WIDTH-1:0] s_awaddr;
  logic [2:0]            s_awprot;
  logic                  s_wvalid, s_wready;
  logic [DATA_WIDTH-1:0] s_wdata;
  logic [SW-1:0]         s_wstrb;
  logic                  s_bvalid, s_bready;
  resp_t                 s_bresp;
  logic                  s_arvalid, s_arready;
  logic [ADDR_WIDTH-1:0] s_araddr;
  logic [2:0]            s_arprot;
  logic                  s_rvalid, s_rready;
  logic [DATA_WIDTH-1:0] s_rdata;
  resp_t                 s_rresp;

  logic                  m_awvalid, m_awready;
  logic [ID_WIDTH-1:0]   m_awid;
  logic [ADDR_WIDTH-1:0] m_awaddr;
  logic [7:0]            m_awlen;
  logic [2:0]            m_awsize;
  logic [1:0]            m_awburst;
  logic                  m_awlock;
  logic [3:0]            m_awcache;
  logic [2:0]            m_awprot;
  logic [3:0]            m_awqos;
  logic                  m_wvalid, m_wready;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic [SW-1:0]         m_wstrb;
  logic                  m_wlast;
  logic                  m_bvalid, m_bready;
  logic [ID_WIDTH-1:0]   m_bid;
  resp_t                 m_bresp;
  logic                  m_arvalid, m_arready;
  logic [ID_WIDTH-1:0]   m_arid;
  logic [ADDR_WIDTH-1:0] m_araddr;
  logic [7:0]            m_arlen;
  logic [2:0]            m_arsize;
  logic [1:0]            m_arburst;
  logic                  m_arlock;
  logic [3:0]            m_arcache;
  logic [2:0]            m_arprot;
  logic [3:0]            m_arqos;
  logic                  m_rvalid, m_rready;
  logic [ID_WIDTH-1:0]   m_rid;
  logic [DATA_WIDTH-1:0] m_rdata;
  resp_t                 m_rresp;
  logic                  m_rlast;

  modport slave (
    input  s_awvalid, s_awaddr, s_awprot, output s_awready,
    input  s_wvalid, s_wdata, s_wstrb, output s_wready,
    output s_bvalid, s_bresp, input s_bready,
    input  s_arvalid, s_araddr, s_arprot, output s_arready,
    output s_rvalid, s_rdata, s_rresp, input s_rready,
    output m_awvalid, m_awid, m_awaddr, m_awlen, m_awsize,
    output m_awburst, m_awlock, m_awcache, m_awprot, m_awqos,
    input  m_awready,
    output m_wvalid, m_wdata, m_wstrb, m_wlast, input m_wready,
    input  m_bvalid, m_bid, m_bresp, output m_bready,
    output m_arvalid, m_arid, m_araddr, m_arlen, m_arsize,
    output m_arburst, m_arlock, m_arcache, m_arprot, m_arqos,
    input  m_arready,
    input  m_rvalid, m_rid, m_rdata, m_rresp, m_rlast,
    output m_rready
  );

  modport master (
    output s_awvalid, s_awaddr, s_awprot, input s_awready,
    output s_wvalid, s_wdata, s_wstrb, input s_wready,
    input  s_bvalid, s_bresp, output s_bready,
    output s_arvalid, s_araddr, s_arprot, input s_arready,
    input  s_rvalid, s_rdata, s_rresp, output s_rready,
    input  m_awvalid, m_awid, m_awaddr, m_awlen, m_awsize,
    input  m_awburst, m_awlock, m_awcache, m_awprot, m_awqos,
    output m_awready,
    input  m_wvalid, m_wdata, m_wstrb, m_wlast, output m_wready,
    output m_bvalid, m_bid, m_bresp, input m_bready,
    input  m_arvalid, m_arid, m_araddr, m_arlen, m_arsize,
    input  m_arburst, m_arlock, m_arcache, m_arprot, m_arqos,
    output m_arready,
    output m_rvalid, m_rid, m_rdata, m_rresp, m_rlast,
    input  m_rready
  );

endinterface

// File: rtl/axi_skid_buffer.sv
// Two-entry registered valid/ready stage; in_ready and out_valid
// both come straight from flops, so ready never reaches valid.
module axi_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] main_q, skid_q;
  logic             main_v, skid_v, rdy_q;
  logic             in_hs, pop, main_n, skid_n;

  assign in_hs = in_valid & rdy_q;
  assign pop   = ~main_v | out_ready;

  always_comb begin
    main_n = main_v;
    skid_n = skid_v;
    if (pop) begin
      main_n = skid_v | in_hs;
      skid_n = 1'b0;
    end else begin
      skid_n = skid_v | in_hs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      rdy_q  <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_v <= main_n;
      skid_v <= skid_n;
      rdy_q  <= ~skid_n;
      if (pop) begin
        if (skid_v) main_q <= skid_q;
        else if (in_hs) main_q <= in_data;
      end else if (in_hs) begin
        skid_q <= in_data;
      end
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = main_v;
  assign out_data  = main_q;
  assign count     = {1'b0, main_v} + {1'b0, skid_v};

endmodule

// File: rtl/axil2axi_credit_bridge.sv
// AXI4-Lite slave to AXI4 master bridge with per-direction credits,
// response timers and sticky protocol/timeout error flags.
module axil2axi_credit_bridge
  import axi_bridge_pkg::*;
#(
  parameter int ID_WIDTH        = 8,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_VALUE        = 0,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic clk,
  input  logic rst_n,
  axil2axi_credit_bridge_if.slave bus,
  input  logic err_clear,
  output logic err_timeout,
  output logic err_protocol
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = DATA_WIDTH / 8;
  localparam int AW = ADDR_WIDTH + 3;
  localparam int TW = (TIMEOUT_CYCLES < 1) ? 1
                    : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] rd_cnt, aw_cnt, w_cnt;
  logic [CW-1:0] rd_n, aw_n, w_n;
  logic [TW-1:0] rd_tmr, wr_tmr, rd_tmr_n, wr_tmr_n;
  logic [1:0]    ar_occ, aw_occ, w_occ, b_occ, r_occ;
  logic          ar_rdy, aw_rdy, w_rdy;
  logic          ar_full, aw_full, w_full;
  logic          ar_hs, aw_hs, w_hs, b_hs, r_hs;
  logic          b_ok, r_ok, rd_to, wr_to, p_set;
  logic [AW-1:0] ar_out, aw_out;
  logic [SW+DATA_WIDTH-1:0] w_out;
  logic [1:0]    b_out;
  logic [DATA_WIDTH+1:0] r_out;
  logic          unused_ok;

  // in-flight = issued on the master side plus still parked in the skid
  assign ar_full = int'(rd_cnt) + int'(ar_occ) >= MAX_OUTSTANDING;
  assign aw_full = int'(aw_cnt) + int'(aw_occ) >= MAX_OUTSTANDING;
  assign w_full  = int'(w_cnt) + int'(w_occ) >= MAX_OUTSTANDING;

  assign bus.s_arready = ar_rdy & ~ar_full;
  assign bus.s_awready = aw_rdy & ~aw_full;
  assign bus.s_wready  = w_rdy & ~w_full;

  axi_skid_buffer #(.WIDTH(AW)) u_ar (
    .clk, .rst_n,
    .in_valid (bus.s_arvalid & ~ar_full),
    .in_ready (ar_rdy),
    .in_data  ({bus.s_arprot, bus.s_araddr}),
    .out_valid(bus.m_arvalid),
    .out_ready(bus.m_arready),
    .out_data (ar_out),
    .count    (ar_occ)
  );

  axi_skid_buffer #(.WIDTH(AW)) u_aw (
    .clk, .rst_n,
    .in_valid (bus.s_awvalid & ~aw_full),
    .in_ready (aw_rdy),
    .in_data  ({bus.s_awprot, bus.s_awaddr}),
    .out_valid(bus.m_awvalid),
    .out_ready(bus.m_awready),
    .out_data (aw_out),
    .count    (aw_occ)
  );

  axi_skid_buffer #(.WIDTH(SW + DATA_WIDTH)) u_w (
    .clk, .rst_n,
    .in_valid (bus.s_wvalid & ~w_full),
    .in_ready (w_rdy),
    .in_data  ({bus.s_wstrb, bus.s_wdata}),
    .out_valid(bus.m_wvalid),
    .out_ready(bus.m_wready),
    .out_data (w_out),
    .count    (w_occ)
  );

  // responses with no matching credit are swallowed here
  axi_skid_buffer #(.WIDTH(2)) u_b (
    .clk, .rst_n,
    .in_valid (bus.m_bvalid & b_ok),
    .in_ready (bus.m_bready),
    .in_data  (bus.m_bresp),
    .out_valid(bus.s_bvalid),
    .out_ready(bus.s_bready),
    .out_data (b_out),
    .count    (b_occ)
  );

  axi_skid_buffer #(.WIDTH(DATA_WIDTH + 2)) u_r (
    .clk, .rst_n,
    .in_valid (bus.m_rvalid & r_ok),
    .in_ready (bus.m_rready),
    .in_data  ({bus.m_rresp, bus.m_rdata}),
    .out_valid(bus.s_rvalid),
    .out_ready(bus.s_rready),
    .out_data (r_out),
    .count    (r_occ)
  );

  assign bus.m_araddr  = ar_out[ADDR_WIDTH-1:0];
  assign bus.m_arprot  = ar_out[AW-1:ADDR_WIDTH];
  assign bus.m_arid    = ID_WIDTH'(ID_VALUE);
  assign bus.m_arlen   = 8'd0;
  assign bus.m_arsize  = size_for_width(DATA_WIDTH);
  assign bus.m_arburst = BURST_INCR;
  assign bus.m_arlock  = 1'b0;
  assign bus.m_arcache = CACHE_NORMAL_NC;
  assign bus.m_arqos   = 4'd0;

  assign bus.m_awaddr  = aw_out[ADDR_WIDTH-1:0];
  assign bus.m_awprot  = aw_out[AW-1:ADDR_WIDTH];
  assign bus.m_awid    = ID_WIDTH'(ID_VALUE);
  assign bus.m_awlen   = 8'd0;
  assign bus.m_awsize  = size_for_width(DATA_WIDTH);
  assign bus.m_awburst = BURST_INCR;
  assign bus.m_awlock  = 1'b0;
  assign bus.m_awcache = CACHE_NORMAL_NC;
  assign bus.m_awqos   = 4'd0;

  assign bus.m_wdata   = w_out[DATA_WIDTH-1:0];
  assign bus.m_wstrb   = w_out[SW+DATA_WIDTH-1:DATA_WIDTH];
  assign bus.m_wlast   = 1'b1;

  assign bus.s_bresp   = resp_t'(b_out);
  assign bus.s_rdata   = r_out[DATA_WIDTH-1:0];
  assign bus.s_rresp   = resp_t'(r_out[DATA_WIDTH+1:DATA_WIDTH]);

  assign unused_ok = ^{b_occ, r_occ, bus.m_bid, bus.m_rid};

  assign ar_hs = bus.m_arvalid & bus.m_arready;
  assign aw_hs = bus.m_awvalid & bus.m_awready;
  assign w_hs  = bus.m_wvalid & bus.m_wready;
  assign b_hs  = bus.m_bvalid & bus.m_bready;
  assign r_hs  = bus.m_rvalid & bus.m_rready;
  assign b_ok  = (aw_cnt != '0) & (w_cnt != '0);
  assign r_ok  = rd_cnt != '0;

  assign p_set = (r_hs & ~r_ok) | (b_hs & ~b_ok)
               | (r_hs & ~bus.m_rlast);

  always_comb begin
    rd_n = rd_cnt + CW'(ar_hs) - CW'(r_hs & r_ok);
    aw_n = aw_cnt + CW'(aw_hs) - CW'(b_hs & b_ok);
    w_n  = w_cnt + CW'(w_hs) - CW'(b_hs & b_ok);
  end

  // timers park at TMAX so a saturated timer fires the flag only once
  always_comb begin
    rd_tmr_n = rd_tmr;
    rd_to    = 1'b0;
    if (rd_cnt == '0 || r_hs) begin
      rd_tmr_n = '0;
    end else if (!bus.m_rvalid && rd_tmr != TMAX) begin
      rd_tmr_n = rd_tmr + TW'(1);
      rd_to    = rd_tmr == TLAST;
    end
  end

  always_comb begin
    wr_tmr_n = wr_tmr;
    wr_to    = 1'b0;
    if (aw_cnt == '0 || b_hs) begin
      wr_tmr_n = '0;
    end else if (!bus.m_bvalid && wr_tmr != TMAX) begin
      wr_tmr_n = wr_tmr + TW'(1);
      wr_to    = wr_tmr == TLAST;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt       <= '0;
      aw_cnt       <= '0;
      w_cnt        <= '0;
      rd_tmr       <= '0;
      wr_tmr       <= '0;
      err_timeout  <= 1'b0;
      err_protocol <= 1'b0;
    end else begin
      rd_cnt       <= rd_n;
      aw_cnt       <= aw_n;
      w_cnt        <= w_n;
      rd_tmr       <= rd_tmr_n;
      wr_tmr       <= wr_tmr_n;
      err_timeout  <= (err_timeout & ~err_clear) | rd_to | wr_to;
      err_protocol <= (err_protocol & ~err_clear) | p_set;
    end
  end

endmodule

// File: tb/tb_axil2axi_credit_bridge.sv
// Scoreboard bench for the credit bridge: directed lite traffic,
// a scripted AXI4 responder and negedge channel monitors.
module tb_axil2axi_credit_bridge;
  import axi_bridge_pkg::*;

  localparam int IW = 8;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IDV = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_clear = 1'b0;
  logic err_timeout, err_protocol;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_seen[5];
  int ar_cyc, aw_cyc, w_cyc, b_cyc, aw_acc_cyc, t_det;

  logic [34:0] exp_ar[$];
  logic [34:0] exp_aw[$];
  logic [35:0] exp_w[$];
  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];
  logic [35:0] e;

  axil2axi_credit_bridge_if #(
    .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) bus ();

  axil2axi_credit_bridge #(
    .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .ID_VALUE(IDV), .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .err_clear(err_clear),
    .err_timeout(err_timeout),
    .err_protocol(err_protocol)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: required event did not happen as expected", nm);
  endtask

  localparam logic [24:0] CONSTS =
    {8'd0, 3'd2, 2'b01, 1'b0, 4'b0011, 4'd0, 3'(IDV)};

  always @(negedge clk) if (rst_n) begin
    if (bus.m_arvalid && bus.m_arready) begin
      if (exp_ar.size() == 0) fail("ar_unexpected");
      else begin
        e = 36'(exp_ar.pop_front());
        chk("m_ar", {bus.m_arprot, bus.m_araddr}, e);
      end
      chk("m_ar_fields", {bus.m_arlen, bus.m_arsize, bus.m_arburst,
          bus.m_arlock, bus.m_arcache, bus.m_arqos,
          bus.m_arid[2:0]}, CONSTS);
      n_seen[0]++;
      ar_cyc = cyc;
    end
    if (bus.m_awvalid && bus.m_awready) begin
      if (exp_aw.size() == 0) fail("aw_unexpected");
      else begin
        e = 36'(exp_aw.pop_front());
        chk("m_aw", {bus.m_awprot, bus.m_awaddr}, e);
      end
      chk("m_aw_fields", {bus.m_awlen, bus.m_awsize, bus.m_awburst,
          bus.m_awlock, bus.m_awcache, bus.m_awqos,
          bus.m_awid[2:0]}, CONSTS);
      n_seen[1]++;
      aw_cyc = cyc;
    end
    if (bus.m_wvalid && bus.m_wready) begin
      if (exp_w.size() == 0) fail("w_unexpected");
      else begin
        e = exp_w.pop_front();
        chk("m_w", {bus.m_wstrb, bus.m_wdata, bus.m_wlast},
            {e, 1'b1});
      end
      n_seen[2]++;
      w_cyc = cyc;
    end
    if (bus.s_bvalid && bus.s_bready) begin
      if (exp_b.size() == 0) fail("b_unexpected");
      else chk("s_bresp", bus.s_bresp, exp_b.pop_front());
      n_seen[3]++;
      b_cyc = cyc;
    end
    if (bus.s_rvalid && bus.s_rready) begin
      if (exp_r.size() == 0) fail("r_unexpected");
      else chk("s_r", {bus.s_rresp, bus.s_rdata}, exp_r.pop_front());
      n_seen[4]++;
    end
  end

  task automatic lite_ar(input logic [31:0] a, input logic [2:0] p);
    int k = 0;
    bus.s_araddr = a;
    bus.s_arprot = p;
    bus.s_arvalid = 1'b1;
    exp_ar.push_back({p, a});
    do begin @(negedge clk); k++; end
    while (!bus.s_arready && k < 200);
    if (!bus.s_arready) fail("ar_accept_wait");
    @(posedge clk); #1 bus.s_arvalid = 1'b0;
  endtask

  task automatic lite_aw(input logic [31:0] a, input logic [2:0] p);
    int k = 0;
    bus.s_awaddr = a;
    bus.s_awprot = p;
    bus.s_awvalid = 1'b1;
    exp_aw.push_back({p, a});
    do begin @(negedge clk); k++; end
    while (!bus.s_awready && k < 200);
    if (!bus.s_awready) fail("aw_accept_wait");
    aw_acc_cyc = cyc;
    @(posedge clk); #1 bus.s_awvalid = 1'b0;
  endtask

  task automatic lite_w(input logic [31:0] d, input logic [3:0] s);
    int k = 0;
    bus.s_wdata = d;
    bus.s_wstrb = s;
    bus.s_wvalid = 1'b1;
    exp_w.push_back({s, d});
    do begin @(negedge clk); k++; end
    while (!bus.s_wready && k < 200);
    if (!bus.s_wready) fail("w_accept_wait");
    @(posedge clk); #1 bus.s_wvalid = 1'b0;
  endtask

  task automatic send_b(input resp_t rs, input bit fwd);
    int k = 0;
    bus.m_bvalid = 1'b1;
    bus.m_bresp = rs;
    bus.m_bid = IW'(IDV);
    if (fwd) exp_b.push_back(rs);
    do begin @(negedge clk); k++; end
    while (!bus.m_bready && k < 200);
    if (!bus.m_bready) fail("b_accept_wait");
    @(posedge clk); #1 bus.m_bvalid = 1'b0;
  endtask

  task automatic send_r(input logic [31:0] d, input resp_t rs,
                        input logic last);
    int k = 0;
    bus.m_rvalid = 1'b1;
    bus.m_rdata = d;
    bus.m_rresp = rs;
    bus.m_rlast = last;
    bus.m_rid = IW'(IDV);
    exp_r.push_back({rs, d});
    do begin @(negedge clk); k++; end
    while (!bus.m_rready && k < 200);
    if (!bus.m_rready) fail("r_accept_wait");
    @(posedge clk); #1 bus.m_rvalid = 1'b0;
    bus.m_rlast = 1'b1;
  endtask

  task automatic wait_seen(input int ch, input int target,
                           input string nm);
    int k = 0;
    while (n_seen[ch] < target && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (n_seen[ch] < target) fail(nm);
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    @(posedge clk); #1 err_clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    foreach (n_seen[i]) n_seen[i] = 0;
    bus.s_awvalid = 0; bus.s_awaddr = 0; bus.s_awprot = 0;
    bus.s_wvalid = 0; bus.s_wdata = 0; bus.s_wstrb = 0;
    bus.s_arvalid = 0; bus.s_araddr = 0; bus.s_arprot = 0;
    bus.s_bready = 1; bus.s_rready = 1;
    bus.m_awready = 1; bus.m_wready = 1; bus.m_arready = 1;
    bus.m_bvalid = 0; bus.m_bid = 0; bus.m_bresp = OKAY;
    bus.m_rvalid = 0; bus.m_rid = 0; bus.m_rdata = 0;
    bus.m_rresp = OKAY; bus.m_rlast = 1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valids", {bus.m_arvalid, bus.m_awvalid, bus.m_wvalid,
        bus.s_bvalid, bus.s_rvalid}, 0);
    chk("rst_readies", {bus.s_arready, bus.s_awready, bus.s_wready,
        bus.m_bready, bus.m_rready}, 0);
    chk("rst_errs", {err_timeout, err_protocol}, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("readies_after_rst", {bus.s_arready, bus.s_awready,
        bus.s_wready, bus.m_bready, bus.m_rready}, 5'h1f);

    // single write
    fork
      lite_aw(32'h0000_1000, 3'b010);
      lite_w(32'hDEAD_BEEF, 4'hF);
    join
    wait_seen(1, 1, "t1_m_aw");
    wait_seen(2, 1, "t1_m_w");
    send_b(OKAY, 1'b1);
    wait_seen(3, 1, "t1_s_b");
    chk("t1_round_trip_ge3", 64'(b_cyc - aw_acc_cyc >= 3), 1);

    // six reads against four credits
    fork
      for (int i = 0; i < 6; i++)
        lite_ar(32'h0000_2000 + 32'(i * 4), 3'b000);
      begin
        wait_seen(0, 4, "t2_four_ar");
        repeat (3) @(posedge clk);
        #1;
        chk("t2_ar_stalled", n_seen[0], 4);
        chk("t2_s_arready_low", bus.s_arready, 0);
        for (int i = 0; i < 6; i++) begin
          wait_seen(0, i + 1, "t2_ar_before_r");
          send_r(32'hA000_0000 + 32'(i), OKAY, 1'b1);
        end
      end
    join
    wait_seen(4, 6, "t2_six_r");
    chk("t2_no_err", {err_timeout, err_protocol}, 0);

    // write data ahead of its address
    lite_w(32'h1234_5678, 4'h3);
    repeat (5) @(posedge clk);
    #1;
    lite_aw(32'h0000_3000, 3'b001);
    wait_seen(1, 2, "t3_m_aw");
    wait_seen(2, 2, "t3_m_w");
    chk("t3_w_before_aw", 64'(w_cyc < aw_cyc), 1);
    send_b(SLVERR, 1'b1);
    wait_seen(3, 2, "t3_s_b");
    chk("t3_cnts_zero", {dut.aw_cnt, dut.w_cnt}, 0);

    // read timeout then late response
    lite_ar(32'h0000_4000, 3'b000);
    wait_seen(0, 7, "t4_m_ar");
    for (int k = 0; k < 40 && !err_timeout; k++) @(negedge clk);
    t_det = cyc;
    chk("t4_timeout_edge", 64'(t_det - ar_cyc - 1), 16);
    @(posedge clk); #1;
    pulse_clear();
    chk("t4_cleared", err_timeout, 0);
    send_r(32'hCAFE_0004, OKAY, 1'b1);
    wait_seen(4, 7, "t4_late_r");
    chk("t4_still_clear", {err_timeout, err_protocol}, 0);

    // spurious B, then a beat with rlast low
    send_b(OKAY, 1'b0);
    chk("t5_spurious_b_perr", err_protocol, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_b_not_fwd", n_seen[3], 2);
    chk("t5_aw_cnt_zero", dut.aw_cnt, 0);
    pulse_clear();
    chk("t5_perr_cleared", err_protocol, 0);
    lite_ar(32'h0000_5000, 3'b000);
    wait_seen(0, 8, "t5_m_ar");
    send_r(32'h0BAD_F00D, OKAY, 1'b0);
    wait_seen(4, 8, "t5_r_fwd");
    chk("t5_rlast_perr", err_protocol, 1);
    pulse_clear();

    // reset with reads in flight
    for (int i = 0; i < 3; i++)
      lite_ar(32'h0000_6000 + 32'(i * 4), 3'b000);
    wait_seen(0, 11, "t6_three_ar");
    rst_n = 1'b0;
    #1;
    chk("t6_valids_in_rst", {bus.m_arvalid, bus.m_awvalid,
        bus.m_wvalid, bus.s_bvalid, bus.s_rvalid}, 0);
    chk("t6_rd_cnt_zero", dut.rd_cnt, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    lite_ar(32'h0000_7000, 3'b100);
    wait_seen(0, 12, "t6_new_ar");
    send_r(32'h7777_0001, EXOKAY, 1'b1);
    wait_seen(4, 9, "t6_new_r");
    chk("t6_queues_drained",
        64'(exp_ar.size() + exp_r.size() + exp_b.size()), 0);
    chk("final_errs", {err_timeout, err_protocol}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
